fetch_prefetch_queue: RTL and testbench
=======================================

// Module: fetch_prefetch_queue
// PURPOSE
//  Instruction-fetch front end feeding the IF/ID pipeline register.
//  - Drives PC requests to an instruction memory with a ready/valid handshake and in-order,
//    variable-latency responses.
//  - Buffers returned words with their PC+4 in a DEPTH-entry FIFO.
//  - Presents one instruction per cycle to ID, with backpressure.
//  - On a taken branch (redirect) it flushes the queue and discards stale in-flight responses.
// PARAMETERS
//  DEPTH     4   FIFO entries and maximum (queued + in-flight) words; power of 2, >=2
//  RESET_PC  0   first fetch address after reset
// PORTS
//  clock        in   1   pipeline clock; all state updates on negedge clock, as in the pipeline
//  reset        in   1   asynchronous, active-high reset
//  imem_req     out  1   request valid
//  imem_addr    out  32  byte address of request (fetch_pc)
//  imem_ready   in   1   memory accepts request this cycle
//  imem_rvalid  in   1   response word valid (in order of acceptance)
//  imem_rdata   in   32  response instruction word
//  redirect     in   1   taken branch from EX/MEM; discard everything older
//  redirect_pc  in   32  branch target
//  out_valid    out  1   out_instr/out_pcplus4 valid for ID
//  out_instr    out  32  head instruction; 32'h00000000 (nop) when out_valid=0
//  out_pcplus4  out  32  head PC+4; 0 when out_valid=0
//  out_ready    in   1   ID consumes head this cycle (0 = stall)
// BEHAVIOUR
//  - State: fetch_pc, resp_pc, FIFO[DEPTH] of {instr, pcplus4}, count, inflight, discard.
//    Counters are $clog2(DEPTH+1) bits.
//  - Reset (async):
//    - fetch_pc = resp_pc = RESET_PC; count = inflight = discard = 0.
//    - imem_req = 0, out_valid = 0, out_instr = 0, out_pcplus4 = 0.
//  - Request:
//    - imem_req = !redirect && (count + inflight) < DEPTH.
//    - Accept = imem_req && imem_ready. On accept: fetch_pc += 4, inflight++.
//    - imem_addr = fetch_pc at all times; it is held stable while imem_req=1 && !imem_ready.
//  - Response (imem_rvalid, inflight > 0):
//    - inflight--.
//    - If discard > 0: discard-- and drop the word.
//    - Otherwise push {imem_rdata, resp_pc+4} and resp_pc += 4.
//    - If inflight = 0, imem_rvalid is a protocol error and is ignored.
//  - Output: out_valid = (count != 0), with head entry registered.
//    - Latency from imem_rvalid to out_valid is one clock; there is no bypass.
//    - Pop when out_valid && out_ready && !redirect.
//    - Push and pop in the same cycle leave count unchanged.
//    - Overflow cannot occur: the request gate reserves a slot for every in-flight word.
//  - Address arithmetic is modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0.
//  - Redirect (highest priority; in that cycle any pop, push and request are suppressed):
//    - FIFO cleared (count = 0); out_valid = 0 from the next cycle.
//    - fetch_pc = resp_pc = redirect_pc.
//    - discard = inflight - (imem_rvalid ? 1 : 0). A response arriving in the redirect
//      cycle is itself dropped, and discard absorbs all older words.
//    - Fetching from redirect_pc resumes the cycle after the redirect.
//    - Back-to-back redirects: the last one wins; discard is recomputed each time.
//  - reset asserted mid-operation: all state returns to reset values immediately.
//    Responses to pre-reset requests are not expected after reset; the memory is reset too.
// TESTING
//  1. Zero-wait memory (ready=1, rvalid one cycle after accept), out_ready=1:
//     - out_instr streams IMemory[0], [1], [2]...
//     - out_pcplus4 reads 4, 8, 12; one instruction per cycle after 2-cycle startup.
//  2. out_ready=0 for 10 cycles:
//     - out_valid stays 1 with the head word unchanged.
//     - count reaches 4 with inflight 0, and imem_req drops.
//     - On release, four words drain back-to-back with no loss or duplication.
//  3. Memory latency 3 cycles, redirect_pc=0x3C while 2 words are in flight:
//     - The next 2 responses are dropped.
//     - The first out_instr after the redirect is IMemory[15], with out_pcplus4 = 0x40.
//  4. redirect in the same cycle as imem_rvalid and out_ready:
//     - No pop and no push.
//     - discard = inflight - 1.
//     - The next valid output is the word at redirect_pc.
//  5. fetch_pc = 0xFFFFFFFC: next imem_addr = 0, out_pcplus4 = 0.
//  6. reset pulsed mid-stream (async, between edges):
//     - out_valid = 0, imem_addr = RESET_PC and imem_req = 0 immediately.
//     - Fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: instruction-fetch front end feeding the IF/ID register.
// Issues PC requests to instruction memory, buffers in-order responses together
// with their PC+4 in a DEPTH-entry FIFO, and presents one instruction per cycle
// to decode with backpressure. A redirect flushes the queue and arranges for the
// stale in-flight responses to be dropped.
//
// Ports
//   clock        pipeline clock; state updates on its falling edge
//   reset        asynchronous, active-high reset
//   imem_req     request valid            imem_addr   request byte address
//   imem_ready   memory accepts request   imem_rvalid response valid
//   imem_rdata   response word
//   redirect     taken branch             redirect_pc branch target
//   out_valid    head entry valid         out_instr   head word (0 when empty)
//   out_pcplus4  head PC+4 (0 when empty) out_ready   decode consumes head
module fetch_prefetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pcplus4,
   input  logic        out_ready
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned SW = CW + 1;
   localparam logic [SW-1:0] DEPTH_W = SW'(DEPTH);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pcplus4;
   } entry_t;

   entry_t          fifo [DEPTH];
   logic [31:0]     fetch_pc;
   logic [31:0]     resp_pc;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   discard;

   logic            accept;
   logic            resp;
   logic            push;
   logic            pop;

   assign imem_addr = fetch_pc;

   // Handshake decode. The request gate counts in-flight words against free
   // FIFO slots, so a returning word always has somewhere to go.
   always_comb begin
      imem_req    = 1'b0;
      accept      = 1'b0;
      resp        = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      out_valid   = 1'b0;
      out_instr   = '0;
      out_pcplus4 = '0;

      imem_req  = !reset && !redirect &&
                  (({1'b0, count} + {1'b0, inflight}) < DEPTH_W);
      accept    = imem_req && imem_ready;
      // A response with nothing outstanding is a protocol error and is ignored.
      resp      = imem_rvalid && (inflight != '0);
      push      = resp && (discard == '0) && !redirect;
      out_valid = (count != '0);
      pop       = out_valid && out_ready && !redirect;
      if (out_valid) begin
         out_instr   = fifo[rd_ptr].instr;
         out_pcplus4 = fifo[rd_ptr].pcplus4;
      end
   end

   // Control state: PCs, FIFO pointers and the three counters.
   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         inflight <= '0;
         discard  <= '0;
      end else if (redirect) begin
         // Every word still outstanding after this cycle is stale; a word
         // returning in this very cycle is dropped directly.
         fetch_pc <= redirect_pc;
         resp_pc  <= redirect_pc;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         inflight <= inflight - CW'(resp);
         discard  <= inflight - CW'(resp);
      end else begin
         if (accept) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         inflight <= inflight + CW'(accept) - CW'(resp);
         if (resp && (discard != '0)) begin
            discard <= discard - CW'(1);
         end
         if (push) begin
            wr_ptr  <= wr_ptr + PW'(1);
            resp_pc <= resp_pc + 32'd4;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // FIFO storage; contents are masked at the output while count is zero.
   always_ff @(negedge clock) begin
      if (push) begin
         fifo[wr_ptr] <= '{instr: imem_rdata, pcplus4: resp_pc + 32'd4};
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: self-checking bench for fetch_prefetch_queue.
// A behavioural instruction memory answers accepted requests in order after a
// configurable latency; word at byte address a is 32'hE0000000 | (a >> 2).
// Inputs change just after the falling edge (memory outputs on the rising
// edge); outputs are compared 1 time unit after the falling edge.
module tb_fetch_prefetch_queue;

   logic        clock;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pcplus4;
   logic        out_ready;

   int checks   = 0;
   int failures = 0;

   fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .clock       (clock),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_instr   (out_instr),
      .out_pcplus4 (out_pcplus4),
      .out_ready   (out_ready)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hE000_0000 | (a >> 2);
   endfunction

   // Instruction memory model: in-order responses, mem_lat edges after accept.
   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t pend[$];
   int    edge_cnt = 0;
   int    mem_lat  = 1;

   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(negedge clock);
         edge_cnt++;
         if (!reset) begin
            if (imem_rvalid && pend.size() > 0) void'(pend.pop_front());
            if (imem_req && imem_ready) pend.push_back('{imem_addr, edge_cnt + mem_lat});
         end
         @(posedge clock);
         if (reset) begin
            pend.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
         end else if (pend.size() > 0 && pend[0].due <= edge_cnt + 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic v, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic req, input logic [31:0] addr);
      chk({tag, ".out_valid"},   32'(out_valid),   32'(v));
      chk({tag, ".out_instr"},   out_instr,        instr);
      chk({tag, ".out_pcplus4"}, out_pcplus4,      pc4);
      chk({tag, ".imem_req"},    32'(imem_req),    32'(req));
      chk({tag, ".imem_addr"},   imem_addr,        addr);
   endtask

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clock);
      #3;
      reset = 1'b0;
   endtask

   typedef struct {
      logic        rdy;
      logic        v;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        req;
      logic [31:0] addr;
   } vec_t;

   vec_t vecs [19];

   initial begin
      // Streaming with zero-wait memory, then a 10-cycle decode stall and release.
      vecs[0]  = '{1'b1, 1'b0, 32'h0,         32'h00, 1'b1, 32'h04};
      vecs[1]  = '{1'b1, 1'b1, 32'hE000_0000, 32'h04, 1'b1, 32'h08};
      vecs[2]  = '{1'b1, 1'b1, 32'hE000_0001, 32'h08, 1'b1, 32'h0C};
      vecs[3]  = '{1'b1, 1'b1, 32'hE000_0002, 32'h0C, 1'b1, 32'h10};
      vecs[4]  = '{1'b0, 1'b1, 32'hE000_0002, 32'h0C, 1'b1, 32'h14};
      for (int i = 5; i < 14; i++)
         vecs[i] = '{1'b0, 1'b1, 32'hE000_0002, 32'h0C, 1'b0, 32'h18};
      vecs[14] = '{1'b1, 1'b1, 32'hE000_0003, 32'h10, 1'b1, 32'h18};
      vecs[15] = '{1'b1, 1'b1, 32'hE000_0004, 32'h14, 1'b1, 32'h1C};
      vecs[16] = '{1'b1, 1'b1, 32'hE000_0005, 32'h18, 1'b1, 32'h20};
      vecs[17] = '{1'b1, 1'b1, 32'hE000_0006, 32'h1C, 1'b1, 32'h24};
      vecs[18] = '{1'b1, 1'b1, 32'hE000_0007, 32'h20, 1'b1, 32'h28};

      reset       = 1'b1;
      imem_ready  = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;
      out_ready   = 1'b1;
      mem_lat     = 1;
      #2;
      check_out("reset", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      @(negedge clock);
      #3;
      reset = 1'b0;

      for (int i = 0; i < 19; i++) begin
         out_ready = vecs[i].rdy;
         step();
         check_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].instr,
                   vecs[i].pc4, vecs[i].req, vecs[i].addr);
      end

      // Redirect to 0x3C with two words in flight at latency 3.
      mem_lat   = 3;
      out_ready = 1'b1;
      do_reset();
      step();
      step();
      redirect    = 1'b1;
      redirect_pc = 32'h3C;
      #1;
      chk("redir3.req_suppressed", 32'(imem_req), 32'h0);
      step();
      redirect = 1'b0;
      #1;
      check_out("redir3.e3", 1'b0, 32'h0, 32'h0, 1'b1, 32'h3C);
      step();
      chk("redir3.e4.valid", 32'(out_valid), 32'h0);
      step();
      chk("redir3.e5.valid", 32'(out_valid), 32'h0);
      step();
      chk("redir3.e6.valid", 32'(out_valid), 32'h0);
      step();
      chk("redir3.e7.valid", 32'(out_valid), 32'h1);
      chk("redir3.e7.instr", out_instr, 32'hE000_000F);
      chk("redir3.e7.pc4", out_pcplus4, 32'h40);
      step();
      chk("redir3.e8.instr", out_instr, 32'hE000_0010);
      chk("redir3.e8.pc4", out_pcplus4, 32'h44);

      // Redirect coinciding with a response and a consuming decode stage.
      mem_lat = 1;
      do_reset();
      step();
      step();
      step();
      check_out("redir4.pre", 1'b1, 32'hE000_0001, 32'h08, 1'b1, 32'h0C);
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      #1;
      check_out("redir4.e4", 1'b0, 32'h0, 32'h0, 1'b1, 32'h100);
      step();
      check_out("redir4.e5", 1'b0, 32'h0, 32'h0, 1'b1, 32'h104);
      step();
      chk("redir4.e6.valid", 32'(out_valid), 32'h1);
      chk("redir4.e6.instr", out_instr, 32'hE000_0040);
      chk("redir4.e6.pc4", out_pcplus4, 32'h104);
      step();
      chk("redir4.e7.instr", out_instr, 32'hE000_0041);
      chk("redir4.e7.pc4", out_pcplus4, 32'h108);

      // Address wrap at the top of the address space.
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      do_reset();
      step();
      redirect = 1'b0;
      #1;
      check_out("wrap.e1", 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFC);
      step();
      chk("wrap.e2.addr", imem_addr, 32'h0);
      step();
      check_out("wrap.e3", 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h4);
      step();
      chk("wrap.e4.instr", out_instr, 32'hE000_0000);
      chk("wrap.e4.pc4", out_pcplus4, 32'h4);
      step();
      chk("wrap.e5.instr", out_instr, 32'hE000_0001);

      // Asynchronous reset between edges, mid-stream.
      #2;
      reset = 1'b1;
      #1;
      check_out("areset.now", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      @(negedge clock);
      #3;
      reset = 1'b0;
      step();
      check_out("areset.e1", 1'b0, 32'h0, 32'h0, 1'b1, 32'h4);
      step();
      check_out("areset.e2", 1'b1, 32'hE000_0000, 32'h4, 1'b1, 32'h8);

      // Memory not ready: address held while the request waits.
      imem_ready = 1'b0;
      step();
      check_out("stall.e3", 1'b1, 32'hE000_0001, 32'h8, 1'b1, 32'h8);
      step();
      check_out("stall.e4", 1'b0, 32'h0, 32'h0, 1'b1, 32'h8);
      imem_ready = 1'b1;
      step();
      check_out("stall.e5", 1'b0, 32'h0, 32'h0, 1'b1, 32'hC);
      step();
      chk("stall.e6.valid", 32'(out_valid), 32'h1);
      chk("stall.e6.instr", out_instr, 32'hE000_0002);
      chk("stall.e6.pc4", out_pcplus4, 32'hC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
